// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator; optional prefetch ports under VGA_TIMING_PREFETCH_EN
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 1,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int FRAME_W  = 8
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  parameter int PREFETCH = 2
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic               vga_on,
  output logic [X_W-1:0]     pixel_x,
  output logic [Y_W-1:0]     pixel_y,
  output logic               pix_ce,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic [X_W-1:0]     pre_x,
  output logic [Y_W-1:0]     pre_y,
  output logic               pre_on
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] X_ACT  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_LO  = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_HI  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_ACT  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_LO  = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_HI  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic       HS_ON    = (HS_POL != 0);
  localparam logic       VS_ON    = (VS_POL != 0);
  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);

  localparam bit PARAMS_OK = (CLK_DIV >= 1) && (CLK_DIV <= 8) &&
                             (H_SYNC > 0) && (V_SYNC > 0) &&
                             (H_TOTAL - 1 < (1 << X_W)) &&
                             (V_TOTAL - 1 < (1 << Y_W));

  logic [2:0]     div_cnt;
  logic [2:0]     div_nxt;
  logic           adv;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic           line_wrap;
  logic           frame_wrap;

  function automatic logic hs_level(input logic [X_W-1:0] x);
    return ((x >= HS_LO) && (x <= HS_HI)) ? HS_ON : ~HS_ON;
  endfunction

  function automatic logic vs_level(input logic [Y_W-1:0] y);
    return ((y >= VS_LO) && (y <= VS_HI)) ? VS_ON : ~VS_ON;
  endfunction

  function automatic logic on_level(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x < X_ACT) && (y < Y_ACT);
  endfunction

  // Divider next value, raster advance decision and next raster position.
  always_comb begin
    adv        = en && (div_cnt == DIV_LAST);
    div_nxt    = (div_cnt == DIV_LAST) ? 3'd0 : div_cnt + 3'd1;
    x_nxt      = pixel_x;
    y_nxt      = pixel_y;
    if (adv) begin
      if (pixel_x == X_LAST) begin
        x_nxt = '0;
        y_nxt = (pixel_y == Y_LAST) ? '0 : pixel_y + 1'b1;
      end else begin
        x_nxt = pixel_x + 1'b1;
      end
    end
    line_wrap  = adv && (x_nxt == '0);
    frame_wrap = line_wrap && (y_nxt == '0);
  end

  // Counters, decoded levels and strobes; decodes use next counts so they line up with pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt   <= 3'd0;
      pixel_x   <= X_LAST;
      pixel_y   <= Y_LAST;
      hsync     <= ~HS_ON;
      vsync     <= ~VS_ON;
      vga_on    <= 1'b0;
      pix_ce    <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      frame_cnt <= '1;
    end else if (en) begin
      div_cnt   <= div_nxt;
      pixel_x   <= x_nxt;
      pixel_y   <= y_nxt;
      hsync     <= hs_level(x_nxt);
      vsync     <= vs_level(y_nxt);
      vga_on    <= on_level(x_nxt, y_nxt);
      pix_ce    <= adv;
      eol       <= line_wrap;
      sof       <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end else begin
      pix_ce <= 1'b0;
      sof    <= 1'b0;
      eol    <= 1'b0;
    end
  end

`ifdef VGA_TIMING_PREFETCH_EN
  // The lookahead position starts PREFETCH pixels after (H_TOTAL-1, V_TOTAL-1), i.e. on line 0.
  localparam logic [X_W-1:0] PRE_X0  = X_W'(PREFETCH - 1);
  localparam logic           PRE_ON0 = (PREFETCH - 1 < H_ACTIVE) && (V_ACTIVE > 0);

  logic [X_W-1:0] pre_x_nxt;
  logic [Y_W-1:0] pre_y_nxt;

  // Lookahead position steps on the same advance as the visible raster.
  always_comb begin
    pre_x_nxt = pre_x;
    pre_y_nxt = pre_y;
    if (adv) begin
      if (pre_x == X_LAST) begin
        pre_x_nxt = '0;
        pre_y_nxt = (pre_y == Y_LAST) ? '0 : pre_y + 1'b1;
      end else begin
        pre_x_nxt = pre_x + 1'b1;
      end
    end
  end

  // Lookahead registers, held with the raster while en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_x  <= PRE_X0;
      pre_y  <= '0;
      pre_on <= PRE_ON0;
    end else if (en) begin
      pre_x  <= pre_x_nxt;
      pre_y  <= pre_y_nxt;
      pre_on <= on_level(pre_x_nxt, pre_y_nxt);
    end
  end
`endif

  // Parameter sanity check, meaningful in simulation only.
  always_ff @(posedge clk) begin
    assert (PARAMS_OK) else $error("vga_timing_gen: illegal parameter set");
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized model-based bench for vga_timing_gen (default and small raster)
module tb_vga_timing_gen;

  localparam int A_DIV = 2;
  localparam int A_HT  = 800;
  localparam int A_VT  = 525;
  localparam int A_FW  = 8;

  localparam int B_DIV = 1;
  localparam int B_HT  = 8;
  localparam int B_VT  = 6;
  localparam int B_FW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic       a_hs, a_vs, a_on, a_pce, a_sof, a_eol;
  logic [9:0] a_x, a_y;
  logic [7:0] a_fc;
  logic       b_hs, b_vs, b_on, b_pce, b_sof, b_eol;
  logic [2:0] b_x, b_y;
  logic [3:0] b_fc;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [9:0] a_px, a_py;
  logic       a_pon;
  logic [2:0] b_px, b_py;
  logic       b_pon;
`endif

  int vectors = 0;
  int miscompares = 0;

  longint a_e = 0;
  longint b_e = 0;
  bit     a_pc = 1'b0;
  bit     b_pc = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(.CLK_DIV(A_DIV)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(a_hs), .vsync(a_vs), .vga_on(a_on),
    .pixel_x(a_x), .pixel_y(a_y),
    .pix_ce(a_pce), .sof(a_sof), .eol(a_eol), .frame_cnt(a_fc)
`ifdef VGA_TIMING_PREFETCH_EN
    , .pre_x(a_px), .pre_y(a_py), .pre_on(a_pon)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CLK_DIV(B_DIV),
    .X_W(3), .Y_W(3), .FRAME_W(B_FW)
`ifdef VGA_TIMING_PREFETCH_EN
    , .PREFETCH(2)
`endif
  ) u_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(b_hs), .vsync(b_vs), .vga_on(b_on),
    .pixel_x(b_x), .pixel_y(b_y),
    .pix_ce(b_pce), .sof(b_sof), .eol(b_eol), .frame_cnt(b_fc)
`ifdef VGA_TIMING_PREFETCH_EN
    , .pre_x(b_px), .pre_y(b_py), .pre_on(b_pon)
`endif
  );

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Position index: advances since reset, offset so advance 0 sits on the last pixel of a frame.
  task automatic check_raster(input string n, input int ht, input int ha, input int hlo, input int hhi,
                              input int vt, input int va, input int vlo, input int vhi,
                              input bit hpol, input bit vpol, input int fw, input int div,
                              input longint e, input bit pc,
                              input longint ox, input longint oy, input longint ofc,
                              input bit ohs, input bit ovs, input bit oon,
                              input bit ope, input bit osof, input bit oeol);
    longint nn, idx, pos, x, y, fr, m;
    nn  = longint'(ht) * vt;
    idx = nn - 1 + e / div;
    pos = idx % nn;
    x   = pos % ht;
    y   = pos / ht;
    fr  = idx / nn;
    m   = longint'(1) << fw;
    check({n, "_x"}, ox, x);
    check({n, "_y"}, oy, y);
    check({n, "_hsync"}, ohs, ((x >= hlo) && (x <= hhi)) ? hpol : !hpol);
    check({n, "_vsync"}, ovs, ((y >= vlo) && (y <= vhi)) ? vpol : !vpol);
    check({n, "_vga_on"}, oon, (x < ha) && (y < va));
    check({n, "_pix_ce"}, ope, pc);
    check({n, "_eol"}, oeol, pc && (x == 0));
    check({n, "_sof"}, osof, pc && (x == 0) && (y == 0));
    check({n, "_frame_cnt"}, ofc, ((fr - 1) % m + m) % m);
  endtask

`ifdef VGA_TIMING_PREFETCH_EN
  task automatic check_pre(input string n, input int ht, input int ha, input int vt, input int va,
                           input int div, input longint e,
                           input longint opx, input longint opy, input bit opon);
    longint nn, pos;
    nn  = longint'(ht) * vt;
    pos = (nn - 1 + e / div + 2) % nn;
    check({n, "_pre_x"}, opx, pos % ht);
    check({n, "_pre_y"}, opy, pos / ht);
    check({n, "_pre_on"}, opon, ((pos % ht) < ha) && ((pos / ht) < va));
  endtask
`endif

  function automatic longint b_pos(input longint e);
    return (longint'(B_HT) * B_VT - 1 + e / B_DIV) % (longint'(B_HT) * B_VT);
  endfunction

  task automatic step(input bit r, input bit e_in);
    rst_n = r;
    en    = e_in;
    @(posedge clk);
    if (!r) begin
      a_e = 0; a_pc = 1'b0;
      b_e = 0; b_pc = 1'b0;
    end else if (e_in) begin
      a_e++; a_pc = (a_e % A_DIV) == 0;
      b_e++; b_pc = (b_e % B_DIV) == 0;
    end else begin
      a_pc = 1'b0;
      b_pc = 1'b0;
    end
    #1;
    check_raster("a", A_HT, 640, 656, 751, A_VT, 480, 490, 491, 1'b0, 1'b0, A_FW, A_DIV,
                 a_e, a_pc, a_x, a_y, a_fc, a_hs, a_vs, a_on, a_pce, a_sof, a_eol);
    check_raster("b", B_HT, 4, 5, 6, B_VT, 3, 4, 4, 1'b1, 1'b1, B_FW, B_DIV,
                 b_e, b_pc, b_x, b_y, b_fc, b_hs, b_vs, b_on, b_pce, b_sof, b_eol);
`ifdef VGA_TIMING_PREFETCH_EN
    check_pre("a", A_HT, 640, A_VT, 480, A_DIV, a_e, a_px, a_py, a_pon);
    check_pre("b", B_HT, 4, B_VT, 3, B_DIV, b_e, b_px, b_py, b_pon);
`endif
    @(negedge clk);
  endtask

  initial begin
    int n;
    @(negedge clk);
    // Reset with en toggling: reset must win.
    repeat (3) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b1);

    // Freeze the small raster at x=2, y=1 for 10 clocks.
    n = 0;
    while (b_pos(b_e) != (1 * B_HT + 2) && n < 200) begin
      step(1'b1, 1'b1);
      n++;
    end
    check("freeze_reach", n, (n < 200) ? n : -1);
    repeat (10) step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1);

    // Reset in the middle of the small-raster vsync line.
    n = 0;
    while ((b_pos(b_e) / B_HT) != 4 && n < 200) begin
      step(1'b1, 1'b1);
      n++;
    end
    check("vsync_reach", n, (n < 200) ? n : -1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    repeat (60) step(1'b1, 1'b1);

    // Long randomized run with random stalls, then stalls plus random resets.
    repeat (12000) step(1'b1, ($urandom % 6) != 0);
    repeat (3000) step(($urandom % 100) != 0, ($urandom % 4) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
